// File: rtl/controller.sv
// Host byte-stream write controller: parses 5-byte packets (0x19, target, addr lo, addr hi, data)
// and issues a single-cycle one-hot write strobe to the selected target memory.
//
// state   | meaning
// IDLE    | waiting for opcode 0x19
// TARGET  | expecting target index byte
// ADDR_LO | expecting address low byte
// ADDR_HI | expecting address high byte
// DATA    | expecting data byte
// EXEC    | one-cycle write strobe on en_ctrl
// WAIT    | waiting for w_finished from target
module controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [7:0]  data_in,
    input  logic [2:0]  convin,
    input  logic        w_finished,
    output logic [7:0]  data_out,
    output logic [9:0]  en_ctrl,
    output logic [15:0] address_written
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TARGET  = 3'd1,
        ADDR_LO = 3'd2,
        ADDR_HI = 3'd3,
        DATA    = 3'd4,
        EXEC    = 3'd5,
        WAIT    = 3'd6
    } state_t;

    localparam logic [7:0] OPCODE_WRITE = 8'h19;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [7:0]  buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [7:0]  target_q, target_d;
    logic [9:0]  en_ctrl_q, en_ctrl_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [15:0] addr_q, addr_d;

    logic        valid_clean;
    logic        byte_fall;
    logic        byte_avail;
    logic        consuming;
    logic [7:0]  byte_cur;
    logic        convin_unused;

    assign convin_unused = ^convin;

    always_comb begin
        // X/Z on valid must never register as a strobe
        valid_clean = (valid === 1'b1);
        byte_fall   = valid_q & ~valid_clean;
        byte_avail  = byte_fall | pend_q;
        // a byte falling this cycle bypasses the buffer so the strobe follows capture by one cycle
        byte_cur    = byte_fall ? data_in : buf_q;
        consuming   = (state_q == IDLE) || (state_q == TARGET) || (state_q == ADDR_LO) ||
                      (state_q == ADDR_HI) || (state_q == DATA);

        state_d    = state_q;
        valid_d    = valid_clean;
        buf_d      = buf_q;
        pend_d     = pend_q;
        target_d   = target_q;
        en_ctrl_d  = '0;
        data_out_d = data_out_q;
        addr_d     = addr_q;

        if (byte_fall) begin
            buf_d  = data_in;
            pend_d = 1'b1;
        end

        if (consuming && byte_avail) begin
            pend_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (byte_cur == OPCODE_WRITE) state_d = TARGET;
                end
                TARGET: begin
                    target_d = byte_cur;
                    state_d  = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_d[7:0] = byte_cur;
                    state_d     = ADDR_HI;
                end
                ADDR_HI: begin
                    addr_d[15:8] = byte_cur;
                    state_d      = DATA;
                end
                DATA: begin
                    data_out_d = byte_cur;
                    state_d    = EXEC;
                    if (target_q < 8'd10) en_ctrl_d = 10'd1 << target_q[3:0];
                end
                default: state_d = state_q;
            endcase
        end

        if (state_q == EXEC) begin
            state_d = w_finished ? IDLE : WAIT;
        end else if (state_q == WAIT) begin
            if (w_finished) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            buf_q      <= '0;
            pend_q     <= 1'b0;
            target_q   <= '0;
            en_ctrl_q  <= '0;
            data_out_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
            target_q   <= target_d;
            en_ctrl_q  <= en_ctrl_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
        end
    end

    assign en_ctrl         = en_ctrl_q;
    assign data_out        = data_out_q;
    assign address_written = addr_q;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: byte-stream reference model checked every cycle, plus directed
// packet scenarios with literal expectations on the observed write strobes.
module tb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [7:0]  data_in;
    logic [2:0]  convin;
    logic        w_finished;
    logic [7:0]  data_out;
    logic [9:0]  en_ctrl;
    logic [15:0] address_written;

    controller dut (
        .clk             (clk),
        .reset           (reset),
        .valid           (valid),
        .data_in         (data_in),
        .convin          (convin),
        .w_finished      (w_finished),
        .data_out        (data_out),
        .en_ctrl         (en_ctrl),
        .address_written (address_written)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet parse position, pending byte, and busy phase
    logic        m_prev = 1'b0;
    logic        m_have = 1'b0;
    logic [7:0]  m_pend = '0;
    int          m_pos  = 0;
    int          m_busy = 0;
    logic [7:0]  m_tgt  = '0;
    logic [9:0]  m_en   = '0;
    logic [7:0]  m_data = '0;
    logic [15:0] m_addr = '0;
    logic        m_fell;
    logic [7:0]  m_byte;
    logic [9:0]  m_new_en;

    always @(posedge clk) begin
        if (reset) begin
            m_prev = 0; m_have = 0; m_pend = 0; m_pos = 0; m_busy = 0;
            m_tgt = 0; m_en = 0; m_data = 0; m_addr = 0;
        end else begin
            m_fell   = m_prev && !valid;
            m_new_en = '0;
            if (m_busy != 0) begin
                if (m_fell) begin
                    m_pend = data_in;
                    m_have = 1;
                end
                m_busy = w_finished ? 0 : 2;
            end else if (m_fell || m_have) begin
                m_byte = m_fell ? data_in : m_pend;
                m_have = 0;
                case (m_pos)
                    0: if (m_byte == 8'h19) m_pos = 1;
                    1: begin m_tgt = m_byte; m_pos = 2; end
                    2: begin m_addr[7:0] = m_byte; m_pos = 3; end
                    3: begin m_addr[15:8] = m_byte; m_pos = 4; end
                    default: begin
                        m_data = m_byte;
                        m_pos  = 0;
                        m_busy = 1;
                        if (m_tgt < 10) m_new_en = 10'(1 << m_tgt);
                    end
                endcase
            end
            m_en   = m_new_en;
            m_prev = valid;
        end
    end

    logic [9:0]  p_en[$];
    logic [15:0] p_addr[$];
    logic [7:0]  p_data[$];

    always @(negedge clk) begin
        chk("en_ctrl", 32'(en_ctrl), 32'(m_en));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("address_written", 32'(address_written), 32'(m_addr));
        if (en_ctrl != 0) begin
            p_en.push_back(en_ctrl);
            p_addr.push_back(address_written);
            p_data.push_back(data_out);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        valid   = 1'b1;
        data_in = b;
        @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        p_en.delete();
        p_addr.delete();
        p_data.delete();
    endtask

    task automatic chk_pulse(input string name, input int idx, input logic [9:0] en,
                             input logic [15:0] addr, input logic [7:0] dat);
        if (p_en.size() > idx) begin
            chk({name, "_en"}, 32'(p_en[idx]), 32'(en));
            chk({name, "_addr"}, 32'(p_addr[idx]), 32'(addr));
            chk({name, "_data"}, 32'(p_data[idx]), 32'(dat));
        end else begin
            tests++;
            fails++;
            $display("FAIL %s: pulse %0d missing, got %0d pulses", name, idx, p_en.size());
        end
    endtask

    logic [7:0] pkt_a[10] = '{8'h19, 8'h06, 8'h00, 8'h00, 8'hA5, 8'h19, 8'h06, 8'h01, 8'h00, 8'h3C};

    initial begin
        reset = 1'b1; valid = 1'b0; data_in = 8'h00; convin = 3'b000; w_finished = 1'b1;
        idle(2);
        chk("reset_en", 32'(en_ctrl), 32'h0);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_addr", 32'(address_written), 32'h0);
        reset = 1'b0;
        idle(1);

        clear_log();
        foreach (pkt_a[i]) send(pkt_a[i], 0);
        idle(4);
        chk("b2b_count", 32'(p_en.size()), 32'd2);
        chk_pulse("pkt1", 0, 10'h040, 16'h0000, 8'hA5);
        chk_pulse("pkt2", 1, 10'h040, 16'h0001, 8'h3C);

        clear_log();
        send(8'h22, 1); send(8'h19, 1); send(8'h02, 1); send(8'h10, 1); send(8'h20, 1); send(8'h77, 1);
        idle(4);
        chk("junk_count", 32'(p_en.size()), 32'd1);
        chk_pulse("junk_pkt", 0, 10'h004, 16'h2010, 8'h77);

        clear_log();
        send(8'h19, 0); send(8'h0C, 0); send(8'h34, 0); send(8'h12, 0); send(8'h99, 0);
        idle(4);
        chk("bad_tgt_count", 32'(p_en.size()), 32'd0);
        chk("bad_tgt_data", 32'(data_out), 32'h99);
        chk("bad_tgt_addr", 32'(address_written), 32'h1234);
        send(8'h19, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        idle(4);
        chk_pulse("after_bad", 0, 10'h002, 16'h0302, 8'h04);

        clear_log();
        w_finished = 1'b0;
        send(8'h19, 0); send(8'h03, 0); send(8'h10, 0); send(8'h00, 0); send(8'h55, 0);
        send(8'h19, 2);
        idle(5);
        chk("wait_count", 32'(p_en.size()), 32'd1);
        chk_pulse("wait_pkt", 0, 10'h008, 16'h0010, 8'h55);
        w_finished = 1'b1;
        idle(2);
        send(8'h05, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
        idle(4);
        chk("buffered_count", 32'(p_en.size()), 32'd2);
        chk_pulse("buffered_pkt", 1, 10'h020, 16'hBBAA, 8'hCC);

        clear_log();
        send(8'h19, 0); send(8'h07, 0); send(8'h55, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("abort_en", 32'(en_ctrl), 32'h0);
        chk("abort_data", 32'(data_out), 32'h0);
        chk("abort_addr", 32'(address_written), 32'h0);
        idle(4);
        chk("abort_count", 32'(p_en.size()), 32'd0);
        send(8'h19, 0); send(8'h08, 0); send(8'hEE, 0); send(8'hDD, 0); send(8'h42, 0);
        idle(4);
        chk_pulse("post_abort", 0, 10'h100, 16'hDDEE, 8'h42);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            w_finished = ($urandom_range(0, 3) != 0);
            if (r == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end else if (r < 3) begin
                send(8'($urandom), $urandom_range(0, 2));
            end else begin
                send(8'h19, $urandom_range(0, 2));
                send(8'($urandom_range(0, 12)), $urandom_range(0, 2));
                for (int k = 0; k < 3; k++) begin
                    w_finished = ($urandom_range(0, 3) != 0);
                    send(8'($urandom), $urandom_range(0, 2));
                end
            end
        end
        w_finished = 1'b1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
